// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the distance-transform statistics stage.
package dt_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int N_PIX = IMG_W * IMG_H;
    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int CNT_W = 15;
    localparam int SUM_W = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dt_stat_acc.sv
// Per-sample statistics datapath: max/argmax, object and threshold counters,
// and the optional distance sum (enabled by DT_STAT_SUM_EN).
module dt_stat_acc
    import dt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    din,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    thr,
    output logic [DW-1:0]    max_val,
    output logic [AW-1:0]    max_addr,
    output logic [CNT_W-1:0] obj_cnt,
    output logic [CNT_W-1:0] thr_cnt,
    output logic [SUM_W-1:0] dist_sum
);

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking writes would let one register see another's new value mid-edge.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            max_val  <= '0;
            max_addr <= '0;
            obj_cnt  <= '0;
            thr_cnt  <= '0;
        end else if (en) begin
            // Strict compare keeps the earliest address on ties.
            if (din > max_val) begin
                max_val  <= din;
                max_addr <= addr;
            end
            if (din != '0) obj_cnt <= obj_cnt + CNT_W'(1);
            if (din >= thr) thr_cnt <= thr_cnt + CNT_W'(1);
        end
    end

`ifdef DT_STAT_SUM_EN
    always_ff @(posedge clk) begin
        if (reset || clr)
            dist_sum <= '0;
        else if (en)
            dist_sum <= dist_sum + SUM_W'(din);
    end
`else
    assign dist_sum = '0;
`endif

endmodule

// File: rtl/dt_stat.sv
// Raster scan of the DT result RAM producing image statistics.
// Optional distance sum is built when DT_STAT_SUM_EN is defined.
module dt_stat
    import dt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DW-1:0]    thr,
    output logic             res_rd,
    output logic [AW-1:0]    res_addr,
    input  logic [DW-1:0]    res_di,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    max_val,
    output logic [AW-1:0]    max_addr,
    output logic [CNT_W-1:0] obj_cnt,
    output logic [CNT_W-1:0] thr_cnt,
    output logic [SUM_W-1:0] dist_sum
);

    state_t        state;
    logic [DW-1:0] thr_q;
    logic          acc_clr;

    assign acc_clr = start && (state == IDLE || state == DONE);

    // res_rd/res_addr double as the sample valid and sample address: the word
    // requested at one edge arrives on res_di in time for the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            res_rd   <= 1'b0;
            res_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            thr_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SCAN;
                        res_rd   <= 1'b1;
                        res_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        thr_q    <= thr;
                    end
                end
                SCAN: begin
                    if (res_addr == AW'(N_PIX - 1)) begin
                        state  <= DRAIN;
                        res_rd <= 1'b0;
                    end else begin
                        res_addr <= res_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dt_stat_acc u_acc (
        .clk      (clk),
        .reset    (reset),
        .clr      (acc_clr),
        .en       (res_rd),
        .din      (res_di),
        .addr     (res_addr),
        .thr      (thr_q),
        .max_val  (max_val),
        .max_addr (max_addr),
        .obj_cnt  (obj_cnt),
        .thr_cnt  (thr_cnt),
        .dist_sum (dist_sum)
    );

endmodule

// File: tb/tb_dt_stat.sv
// Directed self-checking bench for dt_stat with a negedge-registered RAM model.
module tb_dt_stat;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thr;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        busy;
    logic        done;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
    logic [14:0] obj_cnt;
    logic [14:0] thr_cnt;
    logic [21:0] dist_sum;

    logic [7:0] mem [0:16383];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(negedge clk)
        if (res_rd) res_di <= mem[res_addr];

    dt_stat dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr      (thr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .max_addr (max_addr),
        .obj_cnt  (obj_cnt),
        .thr_cnt  (thr_cnt),
        .dist_sum (dist_sum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sum_exp(input logic [31:0] v);
`ifdef DT_STAT_SUM_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 16384; i++) mem[i] = v;
    endtask

    // Pulse start, then follow the scan until done (bounded). Optional extra
    // start pulses with a different thr are injected mid-scan.
    task automatic run_scan(input logic [7:0] t, input bit extra, output int lat,
                            output int rd_n, output int addr_bad);
        @(negedge clk);
        thr   = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        rd_n     = 0;
        addr_bad = 0;
        while (!done && lat < 20000) begin
            if (res_rd) begin
                if (res_addr != rd_n[13:0]) addr_bad++;
                rd_n++;
            end
            if (extra && (lat == 100 || lat == 9000 || lat == 16384)) begin
                start = 1'b1;
                thr   = 8'd200;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_scan(input string tag, input int lat, input int rd_n, input int addr_bad,
                              input int e_max, input int e_addr, input int e_obj,
                              input int e_thr, input int e_sum);
        check({tag, "_latency"}, lat, 16385);
        check({tag, "_rd_cycles"}, rd_n, 16384);
        check({tag, "_addr_seq_errs"}, addr_bad, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_max_val"}, {24'd0, max_val}, e_max);
        check({tag, "_max_addr"}, {18'd0, max_addr}, e_addr);
        check({tag, "_obj_cnt"}, {17'd0, obj_cnt}, e_obj);
        check({tag, "_thr_cnt"}, {17'd0, thr_cnt}, e_thr);
        check({tag, "_dist_sum"}, {10'd0, dist_sum}, sum_exp(e_sum));
    endtask

    initial begin
        int lat, rd_n, addr_bad;
        reset = 1'b1;
        start = 1'b0;
        thr   = 8'd0;
        res_di = 8'd0;
        fill_mem(8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_rd", {31'd0, res_rd}, 0);
        check("rst_res_addr", {18'd0, res_addr}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_max_val", {24'd0, max_val}, 0);
        check("rst_obj_cnt", {17'd0, obj_cnt}, 0);
        check("rst_dist_sum", {10'd0, dist_sum}, 0);
        reset = 1'b0;

        // All-zero image
        run_scan(8'd1, 1'b0, lat, rd_n, addr_bad);
        check_scan("zero", lat, rd_n, addr_bad, 0, 0, 0, 0, 0);

        // Single pixel
        mem[300] = 8'd5;
        run_scan(8'd5, 1'b0, lat, rd_n, addr_bad);
        check_scan("single", lat, rd_n, addr_bad, 5, 300, 1, 1, 5);

        // Tie on max plus last pixel; extra starts mid-scan must be ignored
        fill_mem(8'd0);
        mem[10]    = 8'd9;
        mem[4000]  = 8'd9;
        mem[16383] = 8'd3;
        run_scan(8'd4, 1'b1, lat, rd_n, addr_bad);
        check_scan("tie", lat, rd_n, addr_bad, 9, 10, 3, 2, 21);

        // Saturated image, zero threshold
        fill_mem(8'd255);
        run_scan(8'd0, 1'b0, lat, rd_n, addr_bad);
        check_scan("full", lat, rd_n, addr_bad, 255, 0, 16384, 16384, 4177920);

        // Reset mid-scan at res_addr 5000
        fill_mem(8'd0);
        mem[300] = 8'd5;
        @(negedge clk);
        thr   = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (res_addr != 14'd5000 && lat < 20000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("mid_reach_5000", {18'd0, res_addr}, 5000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_res_rd", {31'd0, res_rd}, 0);
        check("mid_busy", {31'd0, busy}, 0);
        check("mid_done", {31'd0, done}, 0);
        check("mid_max_val", {24'd0, max_val}, 0);
        check("mid_obj_cnt", {17'd0, obj_cnt}, 0);
        check("mid_thr_cnt", {17'd0, thr_cnt}, 0);

        run_scan(8'd5, 1'b0, lat, rd_n, addr_bad);
        check_scan("restart", lat, rd_n, addr_bad, 5, 300, 1, 1, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dt_stat.md
Name: dt_stat

Overview:
- Downstream stage of the distance-transform (DT) block.
- After DT asserts done, it scans the 128x128 8-bit distance map in the result RAM in raster order.
- Produces image statistics: maximum distance and its first location, object-pixel count, and count of pixels at or above a threshold.
- Read-only master on the result-RAM read port; results feed the host/report logic.

Parameters:
- IMG_W, 128, image width in pixels.
- IMG_H, 128, image height in pixels.
- AW, 14, result-RAM address width (log2(IMG_W*IMG_H)).
- DW, 8, distance value width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin scan (tie to DT done rising edge).
- thr  in  8  threshold, latched on accepted start.
- res_rd  out  1  RAM read enable.
- res_addr  out  14  RAM read address.
- res_di  in  8  RAM read data; RAM registers it on negedge, block samples on next posedge.
- busy  out  1  high from accepted start until done.
- done  out  1  level, high when results valid; cleared by next accepted start.
- max_val  out  8  largest distance value.
- max_addr  out  14  lowest raster address holding max_val.
- obj_cnt  out  15  count of pixels != 0.
- thr_cnt  out  15  count of pixels >= latched thr.
- dist_sum  out  22  sum of all distances (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States and transitions:
  - IDLE/DONE -> SCAN on start.
  - SCAN -> DRAIN after address N_PIX-1 is issued.
  - DRAIN -> DONE after the last sample.
  - DONE -> SCAN on start.
- start while busy (SCAN/DRAIN) is ignored.
- On accepted start (edge E0):
  - clear all accumulators, max_val, max_addr, done;
  - latch thr;
  - busy=1, res_rd=1, res_addr=0.
- SCAN: res_addr increments by 1 per cycle. Address k is registered at E0+k, read by the RAM at the following negedge, sampled at E0+k+1.
- res_rd stays high E0..E0+16383 only; it drops with the transition to DRAIN.
- Pipeline: a 1-bit valid plus a registered sample address track each sample. No bubbles; one pixel per cycle.
- Last sample at E0+16384. At E0+16385: done=1, busy=0, outputs stable until next accepted start.
- Total latency start-to-done: 16385 cycles.
- Max update only when sample > max_val (strict), so ties keep the earliest address. All-zero image: max_val=0, max_addr=0.
- thr=0: thr_cnt = 16384. Counters are 15 bits, cannot overflow. res_addr wrap never occurs; the scan stops at 16383.
- Reset mid-scan: immediate IDLE, res_rd=0, busy=0, done=0, partial results discarded.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: DT_STAT_SUM_EN.
- Defined: 22-bit dist_sum accumulates every sample, cleared on accepted start. Max 16384*255 = 4177920 fits without saturation.
- Undefined: no adder or register; dist_sum tied to 0.

Decomposition:
- Shared package dt_pkg:
  - IMG_W, IMG_H, N_PIX=16384, AW, DW, CNT_W=15, SUM_W=22;
  - state enum {IDLE, SCAN, DRAIN, DONE}.
- One sub-module, dt_stat_acc: the sample-valid datapath (max/argmax compare, obj/thr counters, optional sum) with clear and enable inputs.
- The top holds the FSM and address generator.

Test Plan:
- All-zero image, thr=1, start -> done at exactly E0+16385; max_val=0, max_addr=0, obj_cnt=0, thr_cnt=0, dist_sum=0.
- Single pixel value 5 at addr 300, thr=5 -> max_val=5, max_addr=300, obj_cnt=1, thr_cnt=1, dist_sum=5.
- Value 9 at addrs 10 and 4000, value 3 at addr 16383, thr=4 -> max_val=9, max_addr=10, obj_cnt=3, thr_cnt=2, dist_sum=21.
- Every pixel 255, thr=0 -> max_addr=0, obj_cnt=16384, thr_cnt=16384, dist_sum=4177920 (0 if DT_STAT_SUM_EN undefined).
- Extra start pulses during scan -> ignored; done timing unchanged. res_rd high exactly 16384 cycles; res_addr sequence 0..16383.
- reset asserted at res_addr=5000 -> next cycle res_rd=0, busy=0, outputs 0. Restart on the image of scenario 2 -> correct results.
